// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// Holds the sequencer state encoding and the slice width.
// Imported by the top and the slice.
package cla_serial_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_serial_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Latency: zero cycles; all carries come straight from the lookahead terms.
// No handshake: the caller feeds it one nibble pair per cycle.
module cla_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Propagate/generate and fully expanded lookahead carries (no ripple).
  always_comb begin
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built by stepping one 4-bit CLA slice over the nibbles, LSB first.
// Latency: accept at edge k, result valid from edge k+WIDTH/4; one op per WIDTH/4+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module cla_serial_adder_ctrl
  import cla_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;     // already inverted for subtract
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       s_nib;
  logic             co;
  logic             last;

  assign last = (idx == IDX_W'(NIB - 1));

  cla_slice u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .ci (carry),
    .s  (s_nib),
    .co (co)
  );

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        x_nib = a_reg[i*SLICE_W +: SLICE_W];
        y_nib = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, step through nibbles in RUN, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, per-nibble result write, carry chaining and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDX_W'(i)) sum_reg[i*SLICE_W +: SLICE_W] <= s_nib;
          end
          carry <= co;
          if (last) begin
            cout_reg <= co;
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s_nib[3] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
